ha_resp_checker: RTL and testbench
==================================

# ha_resp_checker

Synthesizable response checker for the half-adder block: the receiving end of the stimulus stream a test fixture drives into the adder. It samples each applied vector (a, b) together with the adder's outputs (s, cout) on a valid strobe and compares them against the expected sum a^b and carry a&b. It counts vectors and mismatches, captures the first failing vector, and reports pass/fail when a run completes or times out. It sits beside the adder on the board or in a self-test wrapper, in place of manual waveform inspection.

## Interface
- N_VEC, 4: number of vectors that constitute one complete run (1..2^CNT_W-1).
- CNT_W, 8: width of the vector and error counters.
- TIMEOUT, 255: idle cycles allowed in RUN without vld before aborting (≥1, fits in CNT_W bits).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins or restarts a run.
- vld  in  1  sample strobe; a, b, s and cout are valid this cycle.
- a, b  in  1 each  adder inputs as applied.
- s, cout  in  1 each  adder outputs under check.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE until the next start.
- pass  out  1  valid when done is high: 1 when err_cnt==0, vec_cnt==N_VEC and no timeout.
- timeout  out  1  the run was aborted by idle timeout.
- vec_cnt  out  CNT_W  vectors accepted this run.
- err_cnt  out  CNT_W  mismatches this run; saturates at all-ones.
- fail_idx  out  CNT_W  vec_cnt value of the first mismatching vector.
- fail_val  out  4  {a,b,s,cout} of the first mismatch.
- fail_seen  out  1  fail_idx and fail_val hold a capture.

## Operation
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including counters and capture registers.
- States and transitions:
  - IDLE: on start → RUN.
  - RUN: when the vector completing vec_cnt==N_VEC is accepted, or when the idle counter reaches TIMEOUT → DONE.
  - DONE: on start → RUN.
- Entering RUN clears vec_cnt, err_cnt, the idle counter, timeout, fail_seen, fail_idx, fail_val and done.
- A start pulse while in RUN restarts the run: all counters and captures clear and the state stays in RUN.
- Check on each vld in RUN: mismatch = (s != a^b) | (cout != a&b).
  - vec_cnt increments.
  - On mismatch, err_cnt increments, saturating at 2^CNT_W-1.
  - On the first mismatch, fail_idx takes the pre-increment vec_cnt, fail_val takes {a,b,s,cout}, and fail_seen is set.
- vld in IDLE or DONE is ignored.
- Idle counter: clears on each vld in RUN, otherwise increments. Reaching TIMEOUT sets timeout=1 and moves to DONE.
- Simultaneous events:
  - start and vld in the same cycle: start wins and the vector is discarded.
  - Final vld and timeout in the same cycle: the vector is counted and timeout stays 0.
- pass is combinational from the registered state: done & ~timeout & (err_cnt==0) & (vec_cnt==N_VEC).

## Timing
- Counters, captures and state all update on the edge that samples vld. The new values are visible one cycle after the vld cycle.
- done rises on the edge after the final accepted vector or after the timeout-expiry cycle.
- start to busy=1 latency is 1 cycle.
- Reset deasserts asynchronously into IDLE. A vld in the first cycle after reset release is ignored because the block is not in RUN.
- Inputs are assumed synchronous to clk. Synchronizing them is the instantiating wrapper's responsibility.

## Structure
- Shared package ha_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Function ha_expect(a,b) returning {s,cout}, also used by the half adder's own self-check.
- One sub-module, ha_idle_timer: the idle counter, with clear, enable and TIMEOUT compare, producing an expire pulse.
- Everything else is a single FSM with counters in the top.

## Test plan
- Reset, then start, then the four vectors (00,10,01,11) with correct outputs (00,10,10,01) → done=1, pass=1, vec_cnt=4, err_cnt=0, fail_seen=0.
- Start, then vectors 00,10,01,11 with the third given s=0 → err_cnt=1, fail_idx=2, fail_val=4'b0100, pass=0.
- Start with TIMEOUT=5, one vld, then 5 idle cycles → timeout=1, done=1, pass=0, vec_cnt=1.
- Mid-run start after 2 vectors, including one error → counters and captures clear; then 4 good vectors → pass=1.
- CNT_W=2, N_VEC=3, all three vectors wrong with cout stuck at 1 → err_cnt=3 (at the saturation limit), fail_idx=0.
- rst_n pulsed low mid-run between clock edges → all outputs 0 immediately; a vld before the next start is ignored.

Source files
------------

// File: rtl/ha_pkg.sv
// Shared types and the reference half-adder function used by the response checker
// and by the adder's own self-check.
package ha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {s, cout} for a half adder.
  function automatic logic [1:0] ha_expect(input logic a, input logic b);
    return {a ^ b, a & b};
  endfunction

endpackage

// File: rtl/ha_idle_timer.sv
// Counts idle cycles while enabled; pulses expire on the cycle whose increment
// would reach TIMEOUT, unless that same cycle clears the count.
module ha_idle_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = en & ~clr & (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ha_resp_checker.sv
// Half-adder response checker: compares each sampled vector against the expected
// sum/carry, counts vectors and errors, captures the first failure.
module ha_resp_checker
  import ha_pkg::*;
#(
  parameter int unsigned N_VEC   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fail_idx,
  output logic [3:0]       fail_val,
  output logic             fail_seen
);

  localparam logic [CNT_W-1:0] N_VEC_C = CNT_W'(N_VEC);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] vec_q,       vec_d;
  logic [CNT_W-1:0] err_q,       err_d;
  logic [CNT_W-1:0] fail_idx_q,  fail_idx_d;
  logic [3:0]       fail_val_q,  fail_val_d;
  logic             fail_seen_q, fail_seen_d;
  logic             timeout_q,   timeout_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic             expire;
  logic             mismatch;
  logic [CNT_W-1:0] vec_inc;

  // Kept outside the FSM process so the timer's expire never loops back into its clear.
  assign tmr_clr  = start | (vld & (state_q == RUN));
  assign tmr_en   = (state_q == RUN);
  assign mismatch = ({s, cout} != ha_expect(a, b));
  assign vec_inc  = vec_q + 1'b1;

  ha_idle_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    err_d       = err_q;
    fail_idx_d  = fail_idx_q;
    fail_val_d  = fail_val_q;
    fail_seen_d = fail_seen_q;
    timeout_d   = timeout_q;

    if (start) begin
      // Start wins over a same-cycle vld, from any state.
      state_d     = RUN;
      vec_d       = '0;
      err_d       = '0;
      fail_idx_d  = '0;
      fail_val_d  = '0;
      fail_seen_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (vld) begin
        vec_d = vec_inc;
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_seen_q) begin
            fail_idx_d  = vec_q;
            fail_val_d  = {a, b, s, cout};
            fail_seen_d = 1'b1;
          end
        end
        if (vec_inc == N_VEC_C) begin
          state_d = DONE;
        end
      end else if (expire) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_val_q  <= '0;
      fail_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      fail_idx_q  <= fail_idx_d;
      fail_val_q  <= fail_val_d;
      fail_seen_q <= fail_seen_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign vec_cnt   = vec_q;
  assign err_cnt   = err_q;
  assign fail_idx  = fail_idx_q;
  assign fail_val  = fail_val_q;
  assign fail_seen = fail_seen_q;
  assign pass      = done & ~timeout_q & (err_q == '0) & (vec_q == N_VEC_C);

endmodule

// File: tb/tb_ha_resp_checker.sv
// Directed bench for ha_resp_checker: a main instance (N_VEC=4, TIMEOUT=5) and a
// narrow instance (CNT_W=2, N_VEC=3) for the error-counter limit.
module tb_ha_resp_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic start_s;
  logic vld;
  logic a, b, s, cout;

  logic       busy, done, pass, timeout, fail_seen;
  logic [7:0] vec_cnt, err_cnt, fail_idx;
  logic [3:0] fail_val;

  logic       s_busy, s_done, s_pass, s_timeout, s_fail_seen;
  logic [1:0] s_vec_cnt, s_err_cnt, s_fail_idx;
  logic [3:0] s_fail_val;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ha_resp_checker #(
    .N_VEC   (4),
    .CNT_W   (8),
    .TIMEOUT (5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vld       (vld),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .vec_cnt   (vec_cnt),
    .err_cnt   (err_cnt),
    .fail_idx  (fail_idx),
    .fail_val  (fail_val),
    .fail_seen (fail_seen)
  );

  ha_resp_checker #(
    .N_VEC   (3),
    .CNT_W   (2),
    .TIMEOUT (3)
  ) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .vld       (vld),
    .a         (a),
    .b         (b),
    .s         (s),
    .cout      (cout),
    .busy      (s_busy),
    .done      (s_done),
    .pass      (s_pass),
    .timeout   (s_timeout),
    .vec_cnt   (s_vec_cnt),
    .err_cnt   (s_err_cnt),
    .fail_idx  (s_fail_idx),
    .fail_val  (s_fail_val),
    .fail_seen (s_fail_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic ia, input logic ib, input logic is, input logic ic);
    a = ia; b = ib; s = is; cout = ic; vld = 1'b1;
    tick();
    vld = 1'b0; a = 1'b0; b = 1'b0; s = 1'b0; cout = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic good4();
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 0);
    apply(0, 1, 1, 0);
    apply(1, 1, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; vld = 1'b0;
    a = 1'b0; b = 1'b0; s = 1'b0; cout = 1'b0;
    tick(); tick();
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_pass",      pass,      0);
    check("rst_vec",       vec_cnt,   0);
    check("rst_err",       err_cnt,   0);
    check("rst_fail_seen", fail_seen, 0);
    check("rst_timeout",   timeout,   0);
    rst_n = 1'b1;
    apply(0, 0, 1, 1);
    check("idle_vld_vec",  vec_cnt,   0);
    check("idle_vld_busy", busy,      0);

    // All four vectors correct
    pulse_start();
    check("start_busy", busy, 1);
    good4();
    check("good_done",      done,      1);
    check("good_busy",      busy,      0);
    check("good_pass",      pass,      1);
    check("good_vec",       vec_cnt,   4);
    check("good_err",       err_cnt,   0);
    check("good_fail_seen", fail_seen, 0);
    check("good_timeout",   timeout,   0);
    apply(1, 1, 0, 0);
    check("done_vld_vec", vec_cnt, 4);
    check("done_vld_err", err_cnt, 0);

    // Third vector with s stuck low
    pulse_start();
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 0);
    apply(0, 1, 0, 0);
    apply(1, 1, 0, 1);
    check("err_done",      done,      1);
    check("err_vec",       vec_cnt,   4);
    check("err_err",       err_cnt,   1);
    check("err_fail_idx",  fail_idx,  2);
    check("err_fail_val",  fail_val,  4'b0100);
    check("err_fail_seen", fail_seen, 1);
    check("err_pass",      pass,      0);

    // One vector then idle until timeout
    pulse_start();
    apply(1, 0, 1, 0);
    repeat (4) tick();
    check("to_pre_busy", busy, 1);
    check("to_pre_done", done, 0);
    tick();
    check("to_timeout", timeout, 1);
    check("to_done",    done,    1);
    check("to_pass",    pass,    0);
    check("to_vec",     vec_cnt, 1);

    // Final vector lands on the would-be expiry cycle
    pulse_start();
    apply(0, 0, 0, 0);
    apply(1, 0, 1, 0);
    apply(0, 1, 1, 0);
    repeat (4) tick();
    apply(1, 1, 0, 1);
    check("race_vec",     vec_cnt, 4);
    check("race_timeout", timeout, 0);
    check("race_pass",    pass,    1);

    // Mid-run restart, including start coinciding with a bad vector
    pulse_start();
    apply(0, 0, 0, 0);
    apply(1, 1, 0, 0);
    check("mid_err", err_cnt, 1);
    start = 1'b1;
    apply(1, 1, 1, 1);
    start = 1'b0;
    check("restart_busy",      busy,      1);
    check("restart_vec",       vec_cnt,   0);
    check("restart_err",       err_cnt,   0);
    check("restart_fail_seen", fail_seen, 0);
    check("restart_fail_idx",  fail_idx,  0);
    check("restart_fail_val",  fail_val,  0);
    good4();
    check("restart_pass", pass, 1);
    check("restart_vec4", vec_cnt, 4);

    // Narrow instance: every vector has cout stuck at 1
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    apply(0, 0, 0, 1);
    apply(1, 0, 1, 1);
    apply(0, 1, 1, 1);
    check("sat_done",     s_done,     1);
    check("sat_vec",      s_vec_cnt,  3);
    check("sat_err",      s_err_cnt,  3);
    check("sat_fail_idx", s_fail_idx, 0);
    check("sat_fail_val", s_fail_val, 4'b0001);
    check("sat_pass",     s_pass,     0);

    // Asynchronous reset between edges during a run
    pulse_start();
    apply(0, 0, 0, 0);
    apply(1, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",      busy,      0);
    check("arst_done",      done,      0);
    check("arst_vec",       vec_cnt,   0);
    check("arst_err",       err_cnt,   0);
    check("arst_fail_seen", fail_seen, 0);
    check("arst_fail_idx",  fail_idx,  0);
    check("arst_fail_val",  fail_val,  0);
    check("arst_sat_done",  s_done,    0);
    #1 rst_n = 1'b1;
    apply(1, 0, 1, 0);
    check("post_arst_vec",  vec_cnt, 0);
    check("post_arst_busy", busy,    0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
